// File: rtl/data_cache_controller.sv
// Miss/refill sequencer for a direct-mapped, write-back, write-allocate data cache.
// Owns tag/valid/dirty state and steps the external data array through writeback and refill.
module data_cache_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 64
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          CPU_REQ,
  input  logic                          CPU_WE,
  input  logic [ADDR_WIDTH-1:0]         CPU_ADDR,
  output logic                          CPU_STALL,
  output logic                          CPU_READY,
  output logic [$clog2(LINES)-1:0]      ARR_INDEX,
  output logic [$clog2(LINE_WORDS)-1:0] ARR_WORD,
  output logic                          ARR_WE,
  output logic                          ARR_WSEL,
  output logic                          MEM_REQ,
  output logic                          MEM_WE,
  output logic [ADDR_WIDTH-1:0]         MEM_ADDR,
  input  logic                          MEM_ACK
);

  localparam int unsigned BO = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned OB = BO + WW;
  localparam int unsigned TW = ADDR_WIDTH - OB - IW;

  typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StRefill} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:BO]  req_addr_q;
  logic                    req_we_q;
  logic [WW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tag_q [LINES];
  logic [LINES-1:0]        valid_q, dirty_q;

  logic [IW-1:0] req_idx, cpu_idx;
  logic [TW-1:0] req_tag;
  logic [WW-1:0] req_word;
  logic          hit, last_beat, capture, line_fill, set_dirty;
  logic          unused_addr_lsbs;

  assign req_idx   = req_addr_q[OB+IW-1:OB];
  assign req_tag   = req_addr_q[ADDR_WIDTH-1:OB+IW];
  assign req_word  = req_addr_q[OB-1:BO];
  assign cpu_idx   = CPU_ADDR[OB+IW-1:OB];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_beat = (cnt_q == WW'(LINE_WORDS - 1));

  // Byte offset within a word never affects line handling.
  assign unused_addr_lsbs = ^CPU_ADDR[BO-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    line_fill = 1'b0;
    set_dirty = 1'b0;
    CPU_READY = 1'b0;
    ARR_WORD  = '0;
    ARR_WE    = 1'b0;
    ARR_WSEL  = 1'b0;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    ARR_INDEX = (state_q == StIdle) ? cpu_idx : req_idx;

    case (state_q)
      StIdle: begin
        if (CPU_REQ) begin
          capture = 1'b1;
          state_d = StCompare;
        end
      end
      StCompare: begin
        ARR_WORD = req_word;
        if (hit) begin
          CPU_READY = 1'b1;
          if (req_we_q) begin
            ARR_WE    = 1'b1;
            set_dirty = 1'b1;
          end
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? StWriteback : StRefill;
        end
      end
      StWriteback: begin
        MEM_REQ  = 1'b1;
        MEM_WE   = 1'b1;
        MEM_ADDR = {tag_q[req_idx], req_idx, cnt_q, {BO{1'b0}}};
        ARR_WORD = cnt_q;
        if (MEM_ACK) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = StRefill;
        end
      end
      StRefill: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = {req_tag, req_idx, cnt_q, {BO{1'b0}}};
        ARR_WORD = cnt_q;
        if (MEM_ACK) begin
          ARR_WE   = 1'b1;
          ARR_WSEL = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (last_beat) begin
            line_fill = 1'b1;
            state_d   = StCompare;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    CPU_STALL = (state_q != StIdle) && !CPU_READY;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      req_addr_q <= '0;
      req_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        req_addr_q <= CPU_ADDR[ADDR_WIDTH-1:BO];
        req_we_q   <= CPU_WE;
      end
      if (line_fill) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (set_dirty) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tags need no reset: a line's tag is only consulted once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (line_fill) tag_q[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench: line-level cache model predicts beat lists, array strobes and READY cycle.
module tb_data_cache_controller;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        CPU_REQ = 1'b0;
  logic        CPU_WE = 1'b0;
  logic [31:0] CPU_ADDR = '0;
  logic        CPU_STALL, CPU_READY, ARR_WE, ARR_WSEL, MEM_REQ, MEM_WE;
  logic [5:0]  ARR_INDEX;
  logic [1:0]  ARR_WORD;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK = 1'b0;

  int total = 0;
  int bad = 0;

  logic [21:0] m_tag [64];
  bit          m_valid [64];
  bit          m_dirty [64];

  data_cache_controller dut (
    .CLK(CLK), .RSTN(RSTN), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
    .CPU_STALL(CPU_STALL), .CPU_READY(CPU_READY), .ARR_INDEX(ARR_INDEX), .ARR_WORD(ARR_WORD),
    .ARR_WE(ARR_WE), .ARR_WSEL(ARR_WSEL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  // One core access; wait states per beat are fixed (maxw) or random in 0..maxw.
  task automatic access(input logic [31:0] addr, input logic we, input int maxw, input bit randw,
                        input int exp_ready, input int abort_beat);
    int          idx, nb, b, waitc, wlim, first_rd;
    logic [21:0] tg;
    logic [31:0] ba [8];
    bit          bw [8];
    bit          hit, done, in_beats, fin, ack, aborted, bw_cur;
    logic [4:0]  exp_ctl, got_ctl;
    idx = int'(addr[9:4]);
    tg  = addr[31:10];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    nb  = 0;
    first_rd = 0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int w = 0; w < 4; w++) begin
          ba[nb] = {m_tag[idx], addr[9:4], w[1:0], 2'b00};
          bw[nb] = 1;
          nb++;
        end
      end
      first_rd = nb;
      for (int w = 0; w < 4; w++) begin
        ba[nb] = {tg, addr[9:4], w[1:0], 2'b00};
        bw[nb] = 0;
        nb++;
      end
    end
    b = 0;
    waitc = 0;
    wlim = randw ? int'($urandom_range(maxw, 0)) : maxw;
    done = 0;
    aborted = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      CPU_REQ  = 1'b1;
      CPU_ADDR = addr;
      CPU_WE   = we;
      in_beats = (c >= 2) && (b < nb);
      fin      = hit ? (c == 1) : ((c >= 2) && (b == nb));
      bw_cur   = in_beats ? bw[b] : 0;
      ack      = in_beats ? (waitc == wlim) : ($urandom_range(1, 0) == 1);
      if (abort_beat >= 0 && in_beats && !bw_cur && (b - first_rd) == abort_beat && waitc == 0) begin
        RSTN = 1'b0;
        ack = 0;
        aborted = 1;
      end
      MEM_ACK = ack;
      #1;
      exp_ctl = {in_beats, bw_cur, in_beats ? (ack && !bw_cur) : (fin && we), fin,
                 (c > 0) && !fin};
      got_ctl = {MEM_REQ, MEM_WE, ARR_WE, CPU_READY, CPU_STALL};
      total++;
      if (got_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL ctl addr=%h cycle=%0d req/we/arr_we/ready/stall got=%b want=%b",
                 addr, c, got_ctl, exp_ctl);
      end
      total++;
      if (ARR_INDEX !== addr[9:4]) begin
        bad++;
        $display("FAIL arr_index cycle=%0d got=%h want=%h", c, ARR_INDEX, addr[9:4]);
      end
      if (in_beats) begin
        total++;
        if (MEM_ADDR !== ba[b] || ARR_WORD !== ba[b][3:2]) begin
          bad++;
          $display("FAIL beat%0d cycle=%0d mem_addr got=%h want=%h arr_word got=%0d want=%0d",
                   b, c, MEM_ADDR, ba[b], ARR_WORD, ba[b][3:2]);
        end
        if (ack && !bw_cur) begin
          total++;
          if (ARR_WSEL !== 1'b1) begin
            bad++;
            $display("FAIL refill_wsel cycle=%0d got=%b want=1", c, ARR_WSEL);
          end
        end
      end
      if (fin) begin
        done = 1;
        total++;
        if (ARR_WORD !== addr[3:2] || (we && ARR_WSEL !== 1'b0)) begin
          bad++;
          $display("FAIL compare_word cycle=%0d arr_word got=%0d want=%0d wsel got=%b",
                   c, ARR_WORD, addr[3:2], ARR_WSEL);
        end
        if (exp_ready >= 0) begin
          total++;
          if (c != exp_ready) begin
            bad++;
            $display("FAIL ready_cycle addr=%h got=%0d want=%0d", addr, c, exp_ready);
          end
        end
      end
      if (aborted) done = 1;
      if (in_beats) begin
        if (ack) begin
          b++;
          waitc = 0;
          wlim = randw ? int'($urandom_range(maxw, 0)) : maxw;
        end else begin
          waitc++;
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout addr=%h got=no_ready want=ready", addr);
    end
    if (aborted) begin
      @(posedge CLK);
      #1;
      total++;
      if (MEM_REQ !== 1'b0 || CPU_STALL !== 1'b0) begin
        bad++;
        $display("FAIL abort mem_req got=%b want=0 stall got=%b want=0", MEM_REQ, CPU_STALL);
      end
      CPU_REQ = 1'b0;
      MEM_ACK = 1'b0;
      @(negedge CLK);
      RSTN = 1'b1;
      model_clear();
    end else if (done) begin
      if (!hit) begin
        m_tag[idx]   = tg;
        m_valid[idx] = 1;
        m_dirty[idx] = 0;
      end
      if (we) m_dirty[idx] = 1;
    end
    CPU_REQ = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    RSTN = 1'b0;
    CPU_REQ = 1'b0;
    MEM_ACK = 1'b0;
    CPU_ADDR = $urandom;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    total++;
    if ({CPU_STALL, CPU_READY, ARR_WE, ARR_WSEL, MEM_REQ, MEM_WE} !== 6'b0 ||
        MEM_ADDR !== 32'h0 || ARR_WORD !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b addr=%h word=%0d want=0",
               {CPU_STALL, CPU_READY, ARR_WE, ARR_WSEL, MEM_REQ, MEM_WE}, MEM_ADDR, ARR_WORD);
    end
    a = $urandom;
    CPU_ADDR = a;
    #1;
    total++;
    if (ARR_INDEX !== a[9:4]) begin
      bad++;
      $display("FAIL reset_index got=%h want=%h", ARR_INDEX, a[9:4]);
    end
    RSTN = 1'b1;
    model_clear();
  endtask

  task automatic test_directed();
    access(32'h0000_0100, 1'b0, 0, 0, 6, -1);
    access(32'h0000_0104, 1'b0, 0, 0, 1, -1);
    access(32'h0000_0108, 1'b1, 0, 0, 1, -1);
    access(32'h0000_1100, 1'b0, 0, 0, 10, -1);
    access(32'h0000_0200, 1'b0, 2, 0, 14, -1);
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      CPU_REQ = 1'b0;
      MEM_ACK = ($urandom_range(1, 0) == 1);
      #1;
      total++;
      if ({MEM_REQ, ARR_WE, CPU_STALL, CPU_READY} !== 4'b0) begin
        bad++;
        $display("FAIL idle_ack cycle=%0d got=%b want=0000", i,
                 {MEM_REQ, ARR_WE, CPU_STALL, CPU_READY});
      end
    end
    MEM_ACK = 1'b0;
    access(32'h0000_1104, 1'b0, 0, 0, 1, -1);
    access(32'h0000_0240, 1'b0, 0, 0, 6, -1);
  endtask

  task automatic test_reset_mid_refill();
    access(32'h0000_0300, 1'b0, 0, 0, -1, 1);
    access(32'h0000_0300, 1'b0, 0, 0, 6, -1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = '0;
      a[11:10] = 2'($urandom_range(3, 0));
      a[5:4]   = 2'($urandom_range(3, 0));
      a[3:2]   = 2'($urandom_range(3, 0));
      access(a, ($urandom_range(1, 0) == 1), 2, 1, -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    access(32'h0000_0300, 1'b0, 0, 0, 1, -1);
    access(32'h0000_0304, 1'b1, 0, 0, 1, -1);
    access(32'h0000_030C, 1'b0, 0, 0, 1, -1);
    access(32'h0000_0300, 1'b1, 0, 0, 1, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_spurious_ack();
    test_reset_mid_refill();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Miss/refill controller for the direct-mapped, write-back, write-allocate data cache in the RISC-V memory stage. It owns the tag, valid and dirty state for every line and sequences the external data array. On a miss it writes back a dirty victim line, then refills the line word by word over a single-beat memory handshake. It stalls the core until the access completes.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- LINE_WORDS, 4, words per line (power of two, ≥2)
- LINES, 64, number of lines (power of two)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RSTN  in  1  synchronous reset, active-low
- CPU_REQ  in  1  access request; held stable by core while CPU_STALL=1
- CPU_WE  in  1  1=store, 0=load
- CPU_ADDR  in  ADDR_WIDTH  byte address; [1:0] ignored
- CPU_STALL  out  1  core must hold request
- CPU_READY  out  1  one-cycle pulse: access complete (load data valid at array output / store written)
- ARR_INDEX  out  log2(LINES)  data array line select
- ARR_WORD  out  log2(LINE_WORDS)  data array word select
- ARR_WE  out  1  data array write enable
- ARR_WSEL  out  1  array write source: 0=core store data, 1=memory read data
- MEM_REQ  out  1  memory beat request
- MEM_WE  out  1  1=write beat (data = array read output), 0=read beat
- MEM_ADDR  out  ADDR_WIDTH  word-aligned beat address, [1:0]=0
- MEM_ACK  in  1  beat complete; for reads, memory data valid same cycle

## Operation
- Address split: offset [1:0], word [OB-1:2], index next log2(LINES) bits, tag = remaining upper bits. OB = 2+log2(LINE_WORDS).
- Internal state: tag[LINES], valid[LINES], dirty[LINES], captured request (addr, we), word counter.
- States: IDLE, COMPARE, WRITEBACK, REFILL.
- IDLE: CPU_REQ=1 → capture CPU_ADDR/CPU_WE → COMPARE. Otherwise stay in IDLE.
- COMPARE: hit = valid[idx] && tag[idx]==req_tag.
  - Hit: CPU_READY=1. On a store, also ARR_WE=1, ARR_WSEL=0 and dirty[idx] set. Next state IDLE.
  - Miss with valid && dirty: counter=0 → WRITEBACK.
  - Miss otherwise: counter=0 → REFILL.
- WRITEBACK: MEM_REQ=1, MEM_WE=1, MEM_ADDR={tag[idx], idx, counter, 2'b00}, ARR_WORD=counter. On MEM_ACK the counter increments; on the ACK for word LINE_WORDS-1, the counter returns to 0 and the state moves to REFILL.
- REFILL: MEM_REQ=1, MEM_WE=0, MEM_ADDR={req_tag, idx, counter, 2'b00}. Each MEM_ACK drives ARR_WE=1 and ARR_WSEL=1 in the same cycle (ARR_WORD=counter), then increments the counter. On the last ACK: tag[idx]=req_tag, valid=1, dirty=0, state → COMPARE. The repeated compare is then guaranteed to hit.
- ARR_INDEX=idx of the captured request outside IDLE, and CPU_ADDR index in IDLE. ARR_WORD=req word in COMPARE, counter in WRITEBACK/REFILL.
- CPU_STALL = (state≠IDLE) && !CPU_READY.
- MEM_ACK is ignored when MEM_REQ=0. MEM_REQ stays high continuously through WRITEBACK/REFILL, and the address changes only after an ACK.
- The counter wraps modulo LINE_WORDS. No other arithmetic is performed.

## Timing
- Reset (RSTN=0 at an edge): state=IDLE; all valid and dirty bits cleared; counter=0. All outputs 0, except CPU_STALL=0 and ARR_INDEX following CPU_ADDR.
- Reset mid-WRITEBACK/REFILL: abort immediately; MEM_REQ=0 from the next cycle. Victim data not yet written back is lost by definition.
- Hit latency: request seen in IDLE at cycle 0; CPU_READY at cycle 1; IDLE at cycle 2. Back-to-back hits complete every 2 cycles.
- Clean miss with MEM_ACK every cycle: REFILL in cycles 2..1+LINE_WORDS; COMPARE with READY at cycle 2+LINE_WORDS (6 for defaults).
- Dirty miss: adds LINE_WORDS cycles (READY at cycle 10 for defaults).
- MEM_ACK wait states extend the affected state one cycle per non-ACK cycle. No beat is skipped or repeated.
- A store miss allocates the line, then performs the store in the final COMPARE. The line ends up dirty.

## Test plan
- Reset, then load 0x100 → clean miss: 4 read beats at 0x100,0x104,0x108,0x10C; ARR_WE high with ARR_WSEL=1 on each ACK; READY at cycle 6.
- Repeat load 0x104 → hit; READY at cycle 1; no MEM_REQ.
- Store 0x108 (hit) → ARR_WE=1, ARR_WSEL=0, ARR_WORD=2. Then load 0x1100 (same index, new tag) → 4 write beats at 0x100..0x10C, then 4 read beats at 0x1100..0x110C; READY at cycle 10.
- MEM_ACK asserted only every third cycle during refill → addresses held between ACKs; exactly 4 array writes; READY at cycle 14.
- Assert RSTN=0 during the second refill beat → MEM_REQ=0 next cycle. A following load to the same address misses again (valid was cleared).
- Spurious MEM_ACK pulses while in IDLE → no state, array or counter change.
